// File: rtl/product_accumulator.sv
// Sums a burst of `len` unsigned 16-bit products. The result is valid 1 cycle after the last transfer and is held until out_ready is seen.
// in_ready is a decode of the state register only; it does not depend on in_valid.
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [15:0]      product,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;

  // The extra top bit of the sum is the carry that feeds the sticky ovf flag.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, product};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: a 24-bit and a 17-bit accumulator share one stimulus; vectors are table-driven, plus hand-written corner sequences.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] product;
  logic        out_ready;

  logic        in_ready, out_valid, ovf, busy;
  logic [23:0] acc_out;
  logic        in_ready17, out_valid17, ovf17, busy17;
  logic [16:0] acc_out17;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .product(product), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .ovf(ovf), .busy(busy)
  );

  product_accumulator #(.ACC_W(17), .LEN_W(8)) dut17 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .product(product), .in_ready(in_ready17),
    .out_valid(out_valid17), .out_ready(out_ready), .acc_out(acc_out17),
    .ovf(ovf17), .busy(busy17)
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][15:0] prod;
    logic [23:0]      exp_acc;
    logic             exp_ovf;
    logic [16:0]      exp_acc17;
    logic             exp_ovf17;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [7:0] l, input logic [15:0] p0, p1, p2, p3,
                              input logic [23:0] a, input logic o,
                              input logic [16:0] a17, input logic o17);
    vec_t v;
    v.len = l;
    v.prod[0] = p0; v.prod[1] = p1; v.prod[2] = p2; v.prod[3] = p3;
    v.exp_acc = a; v.exp_ovf = o; v.exp_acc17 = a17; v.exp_ovf17 = o17;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    start = 1'b1;
    len   = v.len;
    step();
    start = 1'b0;
    chk($sformatf("v%0d busy", k), {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d in_ready[%0d]", k, i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d out_valid_early[%0d]", k, i), {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      product  = v.prod[i];
      step();
      in_valid = 1'b0;
    end
    chk($sformatf("v%0d out_valid", k), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d in_ready_hold", k), {31'd0, in_ready}, 32'd0);
    chk($sformatf("v%0d acc", k), {8'd0, acc_out}, {8'd0, v.exp_acc});
    chk($sformatf("v%0d ovf", k), {31'd0, ovf}, {31'd0, v.exp_ovf});
    chk($sformatf("v%0d acc17", k), {15'd0, acc_out17}, {15'd0, v.exp_acc17});
    chk($sformatf("v%0d ovf17", k), {31'd0, ovf17}, {31'd0, v.exp_ovf17});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_drop", k), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d busy_idle", k), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d acc_kept", k), {8'd0, acc_out}, {8'd0, v.exp_acc});
  endtask

  initial begin
    vecs[0] = mk(8'd3, 16'h0001, 16'h00FF, 16'hFE01, 16'h0, 24'h00FF01, 1'b0, 17'h0FF01, 1'b0);
    vecs[1] = mk(8'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 24'h00FFFF, 1'b0, 17'h0FFFF, 1'b0);
    vecs[2] = mk(8'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h03FFFC, 1'b0, 17'h1FFFC, 1'b1);
    vecs[3] = mk(8'd2, 16'h1234, 16'h4321, 16'h0, 16'h0, 24'h005555, 1'b0, 17'h05555, 1'b0);
    vecs[4] = mk(8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 24'h000000, 1'b0, 17'h00000, 1'b0);
    vecs[5] = mk(8'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 24'h02FFFD, 1'b0, 17'h0FFFD, 1'b1);

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; product = '0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst acc", {8'd0, acc_out}, 32'd0);
    chk("rst ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    // First edge after reset release takes the start.
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Zero length: in_ready must never rise, even with in_valid high.
    start = 1'b1; len = 8'd0; in_valid = 1'b1; product = 16'h1234;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("zl in_ready", {31'd0, in_ready}, 32'd0);
      chk("zl out_valid", {31'd0, out_valid}, 32'd1);
      chk("zl acc", {8'd0, acc_out}, 32'd0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("zl idle", {31'd0, busy}, 32'd0);

    // Gaps in the burst and backpressure on the result.
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0; in_valid = 1'b1; product = 16'hFFFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap in_ready", {31'd0, in_ready}, 32'd1);
      chk("gap acc", {8'd0, acc_out}, 32'h00FFFF);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp acc", {8'd0, acc_out}, 32'h01FFFE);
      in_valid = (i == 2);
      step();
    end
    in_valid = 1'b0;
    chk("bp acc_after_ivalid", {8'd0, acc_out}, 32'h01FFFE);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp idle busy", {31'd0, busy}, 32'd0);

    // Reset mid-burst clears everything without waiting for a clock edge.
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; in_valid = 1'b1; product = 16'h0100;
    step();
    step();
    in_valid = 1'b0;
    chk("mid acc", {8'd0, acc_out}, 32'h000200);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst busy", {31'd0, busy}, 32'd0);
    chk("mrst in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst acc", {8'd0, acc_out}, 32'd0);
    chk("mrst ovf", {31'd0, ovf}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post rst busy", {31'd0, busy}, 32'd0);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; product = 16'h0010;
    step();
    in_valid = 1'b0;
    chk("post rst out_valid", {31'd0, out_valid}, 32'd1);
    chk("post rst acc", {8'd0, acc_out}, 32'h000010);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // start during ACCUM and during the HOLD handshake must be ignored.
    start = 1'b1; len = 8'd2;
    step();
    len = 8'd9; in_valid = 1'b1; product = 16'h0005;
    step();
    start = 1'b0; product = 16'h0006;
    step();
    in_valid = 1'b0;
    chk("ign out_valid", {31'd0, out_valid}, 32'd1);
    chk("ign acc", {8'd0, acc_out}, 32'h00000B);
    start = 1'b1; len = 8'd3; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("ign busy", {31'd0, busy}, 32'd0);
    chk("ign out_valid_drop", {31'd0, out_valid}, 32'd0);
    step();
    chk("ign still idle", {31'd0, busy}, 32'd0);
    chk("ign acc kept", {8'd0, acc_out}, 32'h00000B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
